// File: rtl/alu_md_controller_if.sv
// Bundles the EX-stage decode inputs, operands and M-extension results.
interface alu_md_controller_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            RType;
    logic            in_valid;
    logic            flush;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      Operation;
    logic            in_ready;
    logic            stall;
    logic            md_valid;
    logic [XLEN-1:0] md_result;

    // Pipeline side: drives the instruction fields, observes control and results.
    modport master (
        output ALUOp, Funct7, Funct3, RType, in_valid, flush, op_a, op_b,
        input  Operation, in_ready, stall, md_valid, md_result
    );

    // Controller side.
    modport slave (
        input  ALUOp, Funct7, Funct3, RType, in_valid, flush, op_a, op_b,
        output Operation, in_ready, stall, md_valid, md_result
    );
endinterface

// File: rtl/alu_md_controller.sv
// Base ALU operation decode plus an iterative radix-2 MUL/DIV sequencer.
module alu_md_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_md_controller_if.slave  md_if
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_SLL    = 4'b0010;
    localparam logic [3:0] OP_SLT    = 4'b0011;
    localparam logic [3:0] OP_SLTU   = 4'b0100;
    localparam logic [3:0] OP_XOR    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_OR     = 4'b1000;
    localparam logic [3:0] OP_AND    = 4'b1001;
    localparam logic [3:0] OP_PASS_B = 4'b1011;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   p_q, p_d;        // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]     b_q, b_d;        // multiplicand / divisor magnitude
    logic [XLEN-1:0]     a_q, a_d;        // raw dividend for remainder-by-zero
    logic [XLEN-1:0]     res_q, res_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d;
    logic                dz_q, dz_d;

    logic                is_md_c, accept_c;
    logic [3:0]          op_c;
    logic                sgn_a_c, sgn_b_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0]     a_mag_c, b_mag_c;
    logic [XLEN:0]       mul_sum_c, div_t_c, div_diff_c;
    logic [2*XLEN-1:0]   step_c, mul_full_c;
    logic [XLEN-1:0]     div_val_c, result_c;

    assign is_md_c  = (md_if.ALUOp == 2'b10) & md_if.RType & (md_if.Funct7 == 7'b0000001);
    assign accept_c = (state_q == IDLE) & md_if.in_valid & is_md_c & ~md_if.flush;

    // Base ALU operation select from ALUOp/Funct3/Funct7.
    always_comb begin
        op_c = OP_ADD;
        case (md_if.ALUOp)
            2'b00: op_c = OP_ADD;
            2'b11: op_c = OP_PASS_B;
            2'b01: begin
                case (md_if.Funct3[2:1])
                    2'b00:   op_c = OP_SUB;
                    2'b10:   op_c = OP_SLT;
                    2'b11:   op_c = OP_SLTU;
                    default: op_c = OP_ADD;
                endcase
            end
            default: begin
                if (!is_md_c) begin
                    case (md_if.Funct3)
                        3'b000:  op_c = (md_if.RType & md_if.Funct7[5]) ? OP_SUB : OP_ADD;
                        3'b001:  op_c = OP_SLL;
                        3'b010:  op_c = OP_SLT;
                        3'b011:  op_c = OP_SLTU;
                        3'b100:  op_c = OP_XOR;
                        3'b101:  op_c = md_if.Funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  op_c = OP_OR;
                        default: op_c = OP_AND;
                    endcase
                end
            end
        endcase
    end

    // Operand magnitudes; signedness per Funct3 (MULH/MULHSU/DIV/REM treat rs1 as signed).
    always_comb begin
        sgn_a_c = (md_if.Funct3 == 3'b001) | (md_if.Funct3 == 3'b010) |
                  (md_if.Funct3 == 3'b100) | (md_if.Funct3 == 3'b110);
        sgn_b_c = (md_if.Funct3 == 3'b001) | (md_if.Funct3 == 3'b100) |
                  (md_if.Funct3 == 3'b110);
        a_neg_c = sgn_a_c & md_if.op_a[XLEN-1];
        b_neg_c = sgn_b_c & md_if.op_b[XLEN-1];
        a_mag_c = a_neg_c ? XLEN'(-md_if.op_a) : md_if.op_a;
        b_mag_c = b_neg_c ? XLEN'(-md_if.op_b) : md_if.op_b;
    end

    // One radix-2 step: shift-add multiply or restoring divide on magnitudes.
    always_comb begin
        mul_sum_c  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
        div_t_c    = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_diff_c = div_t_c - {1'b0, b_q};
        if (f3_q[2]) begin
            step_c = {(div_diff_c[XLEN] ? div_t_c[XLEN-1:0] : div_diff_c[XLEN-1:0]),
                      p_q[XLEN-2:0], ~div_diff_c[XLEN]};
        end else begin
            step_c = {mul_sum_c, p_q[XLEN-1:1]};
        end
    end

    // Final sign correction and special cases once all iterations are done.
    always_comb begin
        mul_full_c = neg_q ? (2*XLEN)'(-p_q) : p_q;
        div_val_c  = f3_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
        if (!f3_q[2]) begin
            result_c = (f3_q[1:0] == 2'b00) ? mul_full_c[XLEN-1:0] : mul_full_c[2*XLEN-1:XLEN];
        end else if (dz_q) begin
            result_c = f3_q[1] ? a_q : {XLEN{1'b1}};
        end else begin
            result_c = neg_q ? XLEN'(-div_val_c) : div_val_c;
        end
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        a_d     = a_q;
        res_d   = res_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    p_d     = {{XLEN{1'b0}}, a_mag_c};
                    b_d     = b_mag_c;
                    a_d     = md_if.op_a;
                    f3_d    = md_if.Funct3;
                    neg_d   = (md_if.Funct3[2] & md_if.Funct3[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
                    dz_d    = (md_if.op_b == '0);
                end
            end
            CALC: begin
                if (md_if.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(XLEN)) begin
                    state_d = DONE;
                    res_d   = result_c;
                end else begin
                    p_d   = step_c;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            a_q     <= '0;
            res_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            a_q     <= a_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
        end
    end

    assign md_if.Operation = op_c;
    assign md_if.in_ready  = (state_q == IDLE);
    assign md_if.stall     = (state_q == CALC) | ((state_q == IDLE) & md_if.in_valid & is_md_c);
    assign md_if.md_valid  = (state_q == DONE);
    assign md_if.md_result = res_q;
endmodule

// File: tb/tb_alu_md_controller.sv
// Scoreboard bench for alu_md_controller: random + directed M ops and decode checks.
module tb_alu_md_controller;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_md_controller_if #(.XLEN(XLEN)) bus();
    alu_md_controller #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .md_if(bus));

    typedef struct {
        logic [31:0] res;
        int          acc;
        logic [2:0]  f3;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the operation table.
    function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic rt);
        if (aluop == 2'b00) return 4'b0000;
        if (aluop == 2'b11) return 4'b1011;
        if (aluop == 2'b01) begin
            if (f3 <= 3'd1) return 4'b0001;
            if (f3 <= 3'd3) return 4'b0000;
            if (f3 <= 3'd5) return 4'b0011;
            return 4'b0100;
        end
        if (rt && f7 == 7'b0000001) return 4'b0000;
        case (f3)
            3'd0: return (rt && f7[5]) ? 4'b0001 : 4'b0000;
            3'd1: return 4'b0010;
            3'd2: return 4'b0011;
            3'd3: return 4'b0100;
            3'd4: return 4'b0101;
            3'd5: return f7[5] ? 4'b0111 : 4'b0110;
            3'd6: return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    // Reference M-extension result using plain wide arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] u;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin u = {32'b0, b}; p = longint'(sa) * longint'(u); return p[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] sp [6];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF; sp[5] = 32'h2;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Monitor: every md_valid pulse must match the oldest expected result and latency.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.md_valid === 1'b1) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_md_valid: got md_result 0x%0h expected no pulse", bus.md_result);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("md_result_f3_%0d", e.f3), bus.md_result, e.res);
                chk("md_latency", 64'(cyc - e.acc), 64'(XLEN + 1));
            end
        end
    end

    // Present an M op once the sequencer is ready; must be called at a falling edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_res);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        bus.ALUOp    = 2'b10;
        bus.RType    = 1'b1;
        bus.Funct7   = 7'b0000001;
        bus.Funct3   = f3;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        #1;
        chk("stall_before_accept", 64'(bus.stall), 64'd1);
        chk("operation_add_for_md", 64'(bus.Operation), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("accepted", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.Funct3   = 3'($urandom_range(0, 7));
        if (expect_res) sb_q.push_back('{ref_md(f3, a, b), cyc, f3});
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] prev;
        int          sc;
        int          w;
        rst_n        = 1'b1;
        bus.ALUOp    = 2'b00;
        bus.Funct7   = '0;
        bus.Funct3   = '0;
        bus.RType    = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_md_valid", 64'(bus.md_valid), 64'd0);
        chk("reset_md_result", 64'(bus.md_result), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 32'd3, 32'd5, 1'b1);

        // MULH -1 x -1 with stall-length measurement from the acceptance edge.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        sc = 0;
        w  = 0;
        while (bus.md_valid !== 1'b1 && w < 200) begin
            if (bus.stall === 1'b1) sc++;
            @(negedge clk);
            w++;
        end
        chk("stall_cycles_after_accept", 64'(sc), 64'd33);
        chk("stall_in_done", 64'(bus.stall), 64'd0);
        @(negedge clk);

        // Plain SUB is not an M op: no stall, sequencer untouched.
        bus.ALUOp = 2'b10; bus.RType = 1'b1; bus.Funct3 = 3'b000; bus.Funct7 = 7'b0100000;
        bus.in_valid = 1'b1;
        #1;
        chk("sub_operation", 64'(bus.Operation), 64'd1);
        chk("sub_stall", 64'(bus.stall), 64'd0);
        chk("sub_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("sub_in_ready_after_edge", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;

        // Random decode checks.
        for (int i = 0; i < 24; i++) begin
            bus.ALUOp  = 2'($urandom_range(0, 3));
            bus.Funct3 = 3'($urandom_range(0, 7));
            bus.Funct7 = ($urandom_range(0, 2) == 0) ? 7'b0000001 :
                         (($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'($urandom));
            bus.RType  = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("decode_aluop%0d_f3_%0d", bus.ALUOp, bus.Funct3), 64'(bus.Operation),
                64'(ref_op(bus.ALUOp, bus.Funct3, bus.Funct7, bus.RType)));
        end
        @(negedge clk);

        // Directed corner cases.
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd5, 32'd7, 32'd0, 1'b1);
        issue(3'd7, 32'd7, 32'd0, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b1);
        end
        drain();

        // Flush while idle blocks acceptance.
        bus.ALUOp = 2'b10; bus.RType = 1'b1; bus.Funct7 = 7'b0000001; bus.Funct3 = 3'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("flush_idle_blocks", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;

        // Flush ten cycles into CALC: back to IDLE, no pulse, result held.
        prev = bus.md_result;
        issue(3'd0, 32'd1234, 32'd5678, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_calc_idle", 64'(bus.in_ready), 64'd1);
        chk("flush_calc_result_held", 64'(bus.md_result), 64'(prev));
        repeat (45) @(negedge clk);
        chk("flush_no_late_result", 64'(bus.md_result), 64'(prev));
        issue(3'd0, 32'd1234, 32'd5678, 1'b1);
        drain();

        // Asynchronous reset in the middle of CALC.
        issue(3'd7, $urandom, 32'd13, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_rst_md_valid", 64'(bus.md_valid), 64'd0);
        chk("async_rst_md_result", 64'(bus.md_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd5, 32'd100, 32'd7, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
